// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO, one frame at a time.
// State table:  IDLE: line high, waiting for a byte | START: start bit | DATA: bits 0..7, LSB first | STOP: stop bit
module uart_tx_serializer #(
  parameter int unsigned ClksPerBit = 104
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       have_next_i,
  output logic       ack_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BaudLast = 16'(ClksPerBit - 1);

  logic [1:0]  r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_ack;
  logic        r_busy;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BaudLast);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baud <= 16'd0;
          r_bit  <= 3'd0;
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (have_next_i) begin
            r_shift <= data_i;
            r_ack   <= 1'b1;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud  <= 16'd0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // next bit is shift[1] because the shift lands on this same edge
              r_tx  <= r_shift[1];
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud  <= 16'd0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign tx_o   = r_tx;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and randomized checks of uart_tx_serializer at ClksPerBit=4 and ClksPerBit=2.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data4, data2;
  logic       hn4, hn2;
  logic       ack4, tx4, busy4;
  logic       ack2, tx2, busy2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_serializer #(.ClksPerBit(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst_n), .data_i(data4), .have_next_i(hn4),
    .ack_o(ack4), .tx_o(tx4), .busy_o(busy4)
  );

  uart_tx_serializer #(.ClksPerBit(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst_n), .data_i(data2), .have_next_i(hn2),
    .ack_o(ack2), .tx_o(tx2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic hn, input logic [7:0] d);
    if (sel) begin
      hn2 = hn; data2 = d;
    end else begin
      hn4 = hn; data4 = d;
    end
  endtask

  function automatic logic [2:0] outs(input bit sel);
    return sel ? {tx2, ack2, busy2} : {tx4, ack4, busy4};
  endfunction

  // Reference frame: start 0, data LSB first, stop 1, each level held ClksPerBit cycles.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit rand_mid,
                            input bit hold_next, input int chg_at, input logic [7:0] chg_val,
                            output int acc_cyc);
    int c;
    logic [9:0] line;
    c = sel ? 2 : 4;
    line = {1'b1, d, 1'b0};
    drive(sel, 1'b1, d);
    tick();
    acc_cyc = cyc;
    check("accept_outs", {29'd0, outs(sel)}, {29'd0, 3'b011});
    drive(sel, hold_next, d);
    for (int k = 1; k < 10 * c; k++) begin
      if (rand_mid && k < 10 * c - 1) drive(sel, 1'($urandom_range(0, 1)), 8'($urandom));
      if (k == 10 * c - 1) drive(sel, hold_next, d);
      if (k == chg_at) drive(sel, hold_next, chg_val);
      tick();
      check("frame_outs", {29'd0, outs(sel)}, {29'd0, line[k / c], 2'b01});
    end
    tick();
    check("idle_reentry", {29'd0, outs(sel)}, {29'd0, 3'b100});
  endtask

  int a1, a2;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    tick(); tick();
    check("reset4", {29'd0, outs(1'b0)}, {29'd0, 3'b100});
    check("reset2", {29'd0, outs(1'b1)}, {29'd0, 3'b100});
    rst_n = 1'b1;

    // empty FIFO
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty4", {29'd0, outs(1'b0)}, {29'd0, 3'b100});
      check("empty2", {29'd0, outs(1'b1)}, {29'd0, 3'b100});
    end

    // single byte
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, -1, 8'h00, a1);
    tick();
    check("after_single", {29'd0, outs(1'b0)}, {29'd0, 3'b100});

    // back-to-back with have_next held high
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, -1, 8'h00, a1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, -1, 8'h00, a2);
    check("b2b_gap", 32'(a2 - a1), 32'd41);
    tick();
    check("after_b2b", {29'd0, outs(1'b0)}, {29'd0, 3'b100});

    // data change mid-frame
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 10, 8'hC3, a1);

    // minimum divisor
    send_frame(1'b1, 8'h01, 1'b0, 1'b0, -1, 8'h00, a1);

    // async reset during DATA bit 3
    drive(1'b0, 1'b1, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 8'h5A);
    for (int k = 1; k <= 17; k++) tick();
    check("pre_reset_busy", {31'd0, busy4}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {29'd0, outs(1'b0)}, {29'd0, 3'b100});
    drive(1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("in_reset", {29'd0, outs(1'b0)}, {29'd0, 3'b100});
    end
    rst_n = 1'b1;
    send_frame(1'b0, 8'h96, 1'b0, 1'b0, -1, 8'h00, a1);

    // randomized bytes with random input activity mid-frame
    for (int i = 0; i < 6; i++) send_frame(1'b0, 8'($urandom), 1'b1, 1'b0, -1, 8'h00, a1);
    for (int i = 0; i < 4; i++) send_frame(1'b1, 8'($urandom), 1'b1, 1'b0, -1, 8'h00, a1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter ClksPerBit, default 104, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data_i  input  8  head byte of the upstream transmit FIFO; valid while have_next_i=1.
REQ-005 SHALL have port have_next_i  input  1  upstream FIFO holds at least one byte.
REQ-006 SHALL have port ack_o  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-007 SHALL have port tx_o  output  1  serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port busy_o  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-010 SHALL register all outputs; there SHALL be no combinational path from any input to any output.
REQ-011 In IDLE with have_next_i=1, at the clock edge: SHALL latch data_i into an 8-bit shift register, set ack_o=1, set tx_o=0, enter START, and clear the baud counter.
REQ-012 SHALL hold ack_o high for exactly one cycle per accepted byte and never assert ack_o outside the IDLE->START transition.
REQ-013 SHALL not sample have_next_i or data_i in any state other than IDLE.
REQ-014 Baud counter SHALL be a 16-bit counter running 0..ClksPerBit-1; a bit period ends when the count equals ClksPerBit-1, and the counter then wraps to 0.
REQ-015 START SHALL drive tx_o=0 for ClksPerBit cycles, then enter DATA with tx_o = shift register bit 0.
REQ-016 DATA SHALL drive each bit for ClksPerBit cycles, shifting right at the end of each bit period; a 3-bit bit counter SHALL advance 0..7.
REQ-017 At the end of bit 7, DATA SHALL enter STOP with tx_o=1.
REQ-018 STOP SHALL drive tx_o=1 for ClksPerBit cycles, then enter IDLE.
REQ-019 Frame length SHALL be exactly 10*ClksPerBit cycles, measured from the acceptance edge to the IDLE re-entry edge.
REQ-020 SHALL spend a minimum of one cycle in IDLE between frames; the back-to-back frame period SHALL therefore be 10*ClksPerBit+1 cycles.
REQ-021 Frame timing is at least 20 cycles, which exceeds the upstream FIFO's have_next update latency (at most 4 cycles after ack); no additional holdoff logic SHALL be added.
REQ-022 A change of have_next_i or data_i during START/DATA/STOP SHALL have no effect on the frame in progress.
REQ-023 SHALL keep tx_o high continuously while in IDLE; there SHALL be no glitch on tx_o at the IDLE<->START or STOP->IDLE boundaries.

Reset
REQ-024 On reset_i=0, SHALL immediately (asynchronously) set tx_o=1, ack_o=0, busy_o=0, state=IDLE, and clear the baud counter, bit counter, and shift register.
REQ-025 Reset mid-frame SHALL abort the frame without issuing any further ack_o; the byte in progress is lost.
REQ-026 After reset_i deasserts, SHALL accept a byte no earlier than the first rising edge at which reset_i=1 and have_next_i=1.

Verification
REQ-027 Single byte, ClksPerBit=4: data_i=0xA5, have_next_i=1 for one accept -> ack_o high for 1 cycle; tx_o = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; busy_o high for 40 cycles.
REQ-028 Back-to-back, ClksPerBit=4: FIFO model holding 0x00, 0xFF with have_next_i kept high -> exactly 2 ack_o pulses 41 cycles apart; line 0,0x8,1 then 0,1x8,1; no byte skipped or duplicated.
REQ-029 Data change mid-frame: data_i switches 0x3C->0xC3 at cycle 10 of the frame -> transmitted byte is 0x3C; no extra ack_o.
REQ-030 Async reset mid-frame: assert reset_i between clock edges during DATA bit 3 -> tx_o=1 and busy_o=0 before the next edge; once reset releases with have_next_i=1, a new frame starts cleanly with one ack_o.
REQ-031 Empty FIFO: have_next_i=0 for 100 cycles -> tx_o=1, ack_o=0, busy_o=0 throughout.
REQ-032 Minimum divisor, ClksPerBit=2: byte 0x01 -> 20-cycle frame; line 0,1,0,0,0,0,0,0,0,1, each level held 2 cycles.
